// File: rtl/riscv_defines.sv
// Shared definitions for the EX-stage ALU and the offload controller:
// operator encodings, vector-mode constants and the offload FSM states.
package riscv_defines;

  localparam int ALU_OP_WIDTH    = 7;
  localparam int APU_FLAGS_WIDTH = 2;

  localparam logic [1:0] VEC_MODE32 = 2'b00;
  localparam logic [1:0] VEC_MODE16 = 2'b10;
  localparam logic [1:0] VEC_MODE8  = 2'b11;

  // Operators handled by the shared unit rather than the basic ALU
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MIN  = 7'b0010000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MAX  = 7'b0010010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ABS  = 7'b0010100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_CLIP = 7'b0010110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_CNT  = 7'b0110110;

  typedef enum logic [2:0] {
    OFFL_IDLE  = 3'd0,
    OFFL_REQ   = 3'd1,
    OFFL_WAIT  = 3'd2,
    OFFL_DONE  = 3'd3,
    OFFL_DRAIN = 3'd4
  } alu_offload_state_e;

endpackage

// File: rtl/riscv_alu_offload_if.sv
// Request/grant/response bus between the offload controller (master)
// and the shared DSP/APU (slave).
interface riscv_alu_offload_if;
  import riscv_defines::*;

  logic                       apu_req_o;
  logic                       apu_gnt_i;
  logic [ALU_OP_WIDTH-1:0]    apu_op_o;
  logic [31:0]                apu_operand_a_o;
  logic [31:0]                apu_operand_b_o;
  logic [31:0]                apu_operand_c_o;
  logic [APU_FLAGS_WIDTH-1:0] apu_flags_o;
  logic                       apu_rvalid_i;
  logic [31:0]                apu_result_i;

  modport master (
    output apu_req_o, apu_op_o, apu_operand_a_o, apu_operand_b_o,
           apu_operand_c_o, apu_flags_o,
    input  apu_gnt_i, apu_rvalid_i, apu_result_i
  );

  modport slave (
    input  apu_req_o, apu_op_o, apu_operand_a_o, apu_operand_b_o,
           apu_operand_c_o, apu_flags_o,
    output apu_gnt_i, apu_rvalid_i, apu_result_i
  );

endinterface

// File: rtl/riscv_alu_offload_timer.sv
// Saturating timeout counter for the response wait. Expiry is flagged on
// the cycle in which the TIMEOUT_CYCLES-th enabled cycle is reached; with
// TIMEOUT_CYCLES = 0 the counter does not exist and never expires.
module riscv_alu_offload_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic w_unused;
    assign w_unused  = &{1'b0, clk, rst_n, i_clear, i_enable};
    assign o_expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    // Holding at LIMIT keeps expiry asserted while enabled, so a flush
    // that races the timeout still ends the drain on the next cycle.
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Count enabled cycles, saturating at the expiry value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (i_clear) begin
        r_count <= '0;
      end else if (i_enable && (r_count != LIMIT)) begin
        r_count <= r_count + CW'(1);
      end else begin
        r_count <= r_count;
      end
    end

    assign o_expired = i_enable && (r_count == LIMIT);
  end

endmodule

// File: rtl/riscv_alu_offload.sv
// EX-stage offload controller: captures an operator the basic ALU cannot
// execute, issues it to the shared DSP/APU and holds the result until EX
// takes it. ready_o follows the ALU contract so EX stalls transparently.
module riscv_alu_offload
  import riscv_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [ALU_OP_WIDTH-1:0]    operator_i,
  input  logic [31:0]                operand_a_i,
  input  logic [31:0]                operand_b_i,
  input  logic [31:0]                operand_c_i,
  input  logic [APU_FLAGS_WIDTH-1:0] vector_mode_i,
  input  logic                       flush_i,
  input  logic                       ex_ready_i,
  riscv_alu_offload_if.master        apu,
  output logic [31:0]                result_o,
  output logic                       valid_o,
  output logic                       ready_o,
  output logic                       err_o
);

  localparam logic [2:0] ST_IDLE  = OFFL_IDLE;
  localparam logic [2:0] ST_REQ   = OFFL_REQ;
  localparam logic [2:0] ST_WAIT  = OFFL_WAIT;
  localparam logic [2:0] ST_DONE  = OFFL_DONE;
  localparam logic [2:0] ST_DRAIN = OFFL_DRAIN;

  logic [2:0]                 r_state;
  logic [2:0]                 w_next_state;
  logic [ALU_OP_WIDTH-1:0]    r_op;
  logic [31:0]                r_a;
  logic [31:0]                r_b;
  logic [31:0]                r_c;
  logic [APU_FLAGS_WIDTH-1:0] r_flags;
  logic [31:0]                r_result;
  logic                       r_err;
  logic                       w_capture;
  logic                       w_res_load;
  logic [31:0]                w_res_val;
  logic                       w_err_set;
  logic                       w_timer_en;
  logic                       w_expired;

  // The timeout only runs while a response is owed (WAIT and DRAIN)
  assign w_timer_en = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

  riscv_alu_offload_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (~w_timer_en),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  // Next-state, payload capture, result load and error detection
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_res_load   = 1'b0;
    w_res_val    = 32'd0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_err_set = apu.apu_rvalid_i;
        if (en_i && !flush_i) begin
          w_next_state = ST_REQ;
          w_capture    = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_err_set = apu.apu_rvalid_i;
        if (flush_i) begin
          w_next_state = ST_IDLE;
        end else if (apu.apu_gnt_i) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (apu.apu_rvalid_i && flush_i) begin
          w_next_state = ST_IDLE;
        end else if (apu.apu_rvalid_i) begin
          w_next_state = ST_DONE;
          w_res_load   = 1'b1;
          w_res_val    = apu.apu_result_i;
        end else if (flush_i) begin
          w_next_state = ST_DRAIN;
        end else if (w_expired) begin
          w_next_state = ST_DONE;
          w_res_load   = 1'b1;
          w_res_val    = 32'd0;
          w_err_set    = 1'b1;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        w_err_set = apu.apu_rvalid_i;
        if (ex_ready_i || flush_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (apu.apu_rvalid_i) begin
          w_next_state = ST_IDLE;
        end else if (w_expired) begin
          w_next_state = ST_IDLE;
          w_err_set    = 1'b1;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Payload registers: loaded once on acceptance, frozen while requesting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_c     <= 32'd0;
      r_flags <= '0;
    end else if (w_capture) begin
      r_op    <= operator_i;
      r_a     <= operand_a_i;
      r_b     <= operand_b_i;
      r_c     <= operand_c_i;
      r_flags <= vector_mode_i;
    end else begin
      r_op    <= r_op;
      r_a     <= r_a;
      r_b     <= r_b;
      r_c     <= r_c;
      r_flags <= r_flags;
    end
  end

  // Result register and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_result <= w_res_load ? w_res_val : r_result;
      r_err    <= r_err | w_err_set;
    end
  end

  // ready_o: low only while an accepted operation is still outstanding
  always_comb begin
    ready_o = 1'b1;
    case (r_state)
      ST_IDLE:  ready_o = ~en_i;
      ST_REQ:   ready_o = 1'b0;
      ST_WAIT:  ready_o = 1'b0;
      ST_DONE:  ready_o = 1'b1;
      ST_DRAIN: ready_o = 1'b1;
      default:  ready_o = 1'b1;
    endcase
  end

  assign apu.apu_req_o       = (r_state == ST_REQ);
  assign apu.apu_op_o        = r_op;
  assign apu.apu_operand_a_o = r_a;
  assign apu.apu_operand_b_o = r_b;
  assign apu.apu_operand_c_o = r_c;
  assign apu.apu_flags_o     = r_flags;
  assign result_o            = r_result;
  assign valid_o             = (r_state == ST_DONE);
  assign err_o               = r_err;

endmodule

// File: tb/tb_riscv_alu_offload.sv
// Scoreboard bench for riscv_alu_offload (TIMEOUT_CYCLES = 8). The driver
// plays both EX and the shared unit; expected results are queued at issue
// time from the EX-side operands and popped by an independent monitor.
module tb_riscv_alu_offload;
  import riscv_defines::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       en_i;
  logic [ALU_OP_WIDTH-1:0]    operator_i;
  logic [31:0]                operand_a_i, operand_b_i, operand_c_i;
  logic [APU_FLAGS_WIDTH-1:0] vector_mode_i;
  logic                       flush_i;
  logic                       ex_ready_i;
  logic [31:0]                result_o;
  logic                       valid_o, ready_o, err_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  riscv_alu_offload_if apu_if();

  riscv_alu_offload #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_c_i(operand_c_i),
    .vector_mode_i(vector_mode_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .apu(apu_if), .result_o(result_o), .valid_o(valid_o), .ready_o(ready_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // What the shared unit computes for a request; flags perturb the low bits
  function automatic logic [31:0] ref_op(input logic [ALU_OP_WIDTH-1:0] op,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c,
                                         input logic [APU_FLAGS_WIDTH-1:0] f);
    logic [31:0] r;
    case (op)
      ALU_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      ALU_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      ALU_ABS:  r = a[31] ? (32'd0 - a) : a;
      ALU_CNT:  r = 32'($countones(a));
      ALU_CLIP: r = ($signed(a) > $signed(b)) ? b : a;
      default:  r = a + b + c;
    endcase
    return r ^ {30'd0, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete transaction; enters and leaves with the DUT idle at posedge+1
  task automatic do_op(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic [1:0] vm, input int gnt_dly, input int rv_dly,
                       input int stall);
    logic [31:0] resp;
    exp_q.push_back(ref_op(op, a, b, c, vm));
    en_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b;
    operand_c_i = c; vector_mode_i = vm;
    #1;
    chk("ready_c0", {31'd0, ready_o}, 32'd0);
    step(1);
    en_i = 1'b0; operator_i = ALU_OP_WIDTH'($urandom);
    operand_a_i = $urandom; operand_b_i = $urandom; operand_c_i = $urandom;
    vector_mode_i = 2'($urandom);
    for (int k = 0; k < gnt_dly; k++) begin
      chk("req_held", {31'd0, apu_if.apu_req_o}, 32'd1);
      chk("payload_a_held", apu_if.apu_operand_a_o, a);
      step(1);
    end
    chk("req", {31'd0, apu_if.apu_req_o}, 32'd1);
    chk("payload_op", {25'd0, apu_if.apu_op_o}, {25'd0, op});
    chk("payload_b", apu_if.apu_operand_b_o, b);
    chk("payload_c", apu_if.apu_operand_c_o, c);
    chk("payload_flags", {30'd0, apu_if.apu_flags_o}, {30'd0, vm});
    chk("ready_req", {31'd0, ready_o}, 32'd0);
    resp = ref_op(apu_if.apu_op_o, apu_if.apu_operand_a_o, apu_if.apu_operand_b_o,
                  apu_if.apu_operand_c_o, apu_if.apu_flags_o);
    apu_if.apu_gnt_i = 1'b1;
    step(1);
    apu_if.apu_gnt_i = 1'b0;
    for (int k = 0; k < rv_dly; k++) begin
      chk("ready_wait", {31'd0, ready_o}, 32'd0);
      step(1);
    end
    chk("ready_rv", {31'd0, ready_o}, 32'd0);
    apu_if.apu_rvalid_i = 1'b1; apu_if.apu_result_i = resp;
    step(1);
    apu_if.apu_rvalid_i = 1'b0; apu_if.apu_result_i = $urandom;
    chk("valid_latency", {31'd0, valid_o}, 32'd1);
    chk("ready_done", {31'd0, ready_o}, 32'd1);
    step(stall);
    ex_ready_i = 1'b1;
    step(1);
    ex_ready_i = 1'b0;
  endtask

  // Monitor: flag unexpected valids, check holding during stalls, pop on consume
  logic        prev_v = 1'b0;
  logic [31:0] prev_r = 32'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (valid_o && !prev_v && exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_valid: result %h with no pending op at %0t", result_o, $time);
        end
        if (valid_o && prev_v) chk("result_hold", result_o, prev_r);
        if (valid_o && ex_ready_i && exp_q.size() != 0) begin
          chk("result", result_o, exp_q.pop_front());
          prev_v = 1'b0;
        end else begin
          prev_v = valid_o;
        end
        prev_r = result_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [ALU_OP_WIDTH-1:0] ops [5];

  initial begin
    ops = '{ALU_MIN, ALU_MAX, ALU_ABS, ALU_CNT, ALU_CLIP};
    rst_n = 1'b0; en_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
    operator_i = '0; operand_a_i = 32'd0; operand_b_i = 32'd0; operand_c_i = 32'd0;
    vector_mode_i = 2'd0;
    apu_if.apu_gnt_i = 1'b0; apu_if.apu_rvalid_i = 1'b0; apu_if.apu_result_i = 32'd0;
    #12;
    chk("rst_req", {31'd0, apu_if.apu_req_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_payload_a", apu_if.apu_operand_a_o, 32'd0);
    chk("rst_payload_op", {25'd0, apu_if.apu_op_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    #10 rst_n = 1'b1;
    step(1);

    // Minimum latency with ALU_MIN
    do_op(ALU_MIN, 32'hFFFF_FFFE, 32'd5, 32'd0, VEC_MODE32, 0, 0, 0);
    chk("min_err", {31'd0, err_o}, 32'd0);
    // Grant withheld for 4 cycles
    do_op(ALU_MAX, $urandom, $urandom, $urandom, VEC_MODE16, 4, 1, 0);
    // 5-cycle DONE stall, then back-to-back issue
    do_op(ALU_ABS, 32'h8000_0011, $urandom, $urandom, VEC_MODE8, 0, 2, 5);
    do_op(ALU_CNT, $urandom, $urandom, $urandom, VEC_MODE32, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      do_op(ops[$urandom_range(0, 4)], $urandom, $urandom, $urandom, 2'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // Flush in REQ before grant
    en_i = 1'b1; operator_i = ALU_MIN; operand_a_i = $urandom;
    step(1);
    en_i = 1'b0; flush_i = 1'b1;
    chk("flreq_req_before", {31'd0, apu_if.apu_req_o}, 32'd1);
    step(1);
    flush_i = 1'b0;
    chk("flreq_req_drop", {31'd0, apu_if.apu_req_o}, 32'd0);
    chk("flreq_ready", {31'd0, ready_o}, 32'd1);
    step(1);
    chk("flreq_no_valid", {31'd0, valid_o}, 32'd0);

    // Flush in WAIT, response arrives two cycles later and is discarded
    en_i = 1'b1; operator_i = ALU_MAX;
    step(1);
    en_i = 1'b0; apu_if.apu_gnt_i = 1'b1;
    step(1);
    apu_if.apu_gnt_i = 1'b0; flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    chk("drain_ready", {31'd0, ready_o}, 32'd1);
    chk("drain_no_valid", {31'd0, valid_o}, 32'd0);
    step(1);
    apu_if.apu_rvalid_i = 1'b1; apu_if.apu_result_i = 32'h1234_5678;
    step(1);
    apu_if.apu_rvalid_i = 1'b0;
    chk("drain_done_no_valid", {31'd0, valid_o}, 32'd0);
    chk("drain_err", {31'd0, err_o}, 32'd0);
    step(1);
    chk("drain_idle_no_valid", {31'd0, valid_o}, 32'd0);

    // Timeout: DONE after exactly 8 WAIT cycles, result 0, err set
    exp_q.push_back(32'd0);
    en_i = 1'b1; operator_i = ALU_ABS;
    step(1);
    en_i = 1'b0; apu_if.apu_gnt_i = 1'b1;
    step(1);
    apu_if.apu_gnt_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("tmo_wait_no_valid", {31'd0, valid_o}, 32'd0);
      step(1);
    end
    chk("tmo_valid", {31'd0, valid_o}, 32'd1);
    chk("tmo_err", {31'd0, err_o}, 32'd1);
    ex_ready_i = 1'b1;
    step(1);
    ex_ready_i = 1'b0;
    do_op(ALU_MAX, 32'd7, 32'd3, 32'd0, VEC_MODE32, 0, 0, 0);
    chk("err_sticky", {31'd0, err_o}, 32'd1);

    // Reset asserted in WAIT: outputs return to reset values at once
    en_i = 1'b1; operator_i = ALU_CNT; operand_a_i = 32'hFF; vector_mode_i = 2'd3;
    step(1);
    en_i = 1'b0; apu_if.apu_gnt_i = 1'b1;
    step(1);
    apu_if.apu_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_result", result_o, 32'd0);
    chk("arst_err", {31'd0, err_o}, 32'd0);
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    chk("arst_payload_a", apu_if.apu_operand_a_o, 32'd0);
    chk("arst_flags", {30'd0, apu_if.apu_flags_o}, 32'd0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    step(1);
    apu_if.apu_rvalid_i = 1'b1;
    step(1);
    apu_if.apu_rvalid_i = 1'b0;
    chk("late_rvalid_err", {31'd0, err_o}, 32'd1);

    // Reset pulse clears err; spurious rvalid in IDLE sets it again
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("err_cleared", {31'd0, err_o}, 32'd0);
    step(1);
    apu_if.apu_rvalid_i = 1'b1;
    step(1);
    apu_if.apu_rvalid_i = 1'b0;
    chk("spur_err", {31'd0, err_o}, 32'd1);
    chk("spur_ready", {31'd0, ready_o}, 32'd1);
    chk("spur_req", {31'd0, apu_if.apu_req_o}, 32'd0);
    chk("spur_valid", {31'd0, valid_o}, 32'd0);
    do_op(ALU_CLIP, 32'd100, 32'd50, 32'd0, VEC_MODE16, 2, 3, 1);

    step(2);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_alu_offload.md
# riscv_alu_offload

Multi-cycle offload controller in the EX stage, beside the basic ALU used in the shared-DSP configuration. Operators the basic ALU does not implement (MIN/MAX/ABS/CLIP, bit-count, vector variants) are captured, issued to the shared DSP/APU over a req/gnt/rvalid handshake, and the returned result is held until EX accepts it. It drives the same `ready_o` contract as the ALU, so the EX stage stalls on it transparently.

## Interface
- `TIMEOUT_CYCLES`, 0: maximum WAIT cycles before abort; 0 disables the timeout.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en_i` input 1: offload request from EX; operator is unsupported locally.
- `operator_i` input ALU_OP_WIDTH: ALU operator to forward.
- `operand_a_i`, `operand_b_i`, `operand_c_i` input 32 each: operands.
- `vector_mode_i` input 2: VEC_MODE8/16/32, forwarded as flags.
- `flush_i` input 1: pipeline kill; abandon the current operation.
- `ex_ready_i` input 1: EX consumes the result this cycle.
- `apu_req_o` output 1: request to the shared unit.
- `apu_gnt_i` input 1: grant; request accepted this cycle.
- `apu_op_o` output ALU_OP_WIDTH; `apu_operand_a_o`, `apu_operand_b_o`, `apu_operand_c_o` output 32 each; `apu_flags_o` output 2: registered payload.
- `apu_rvalid_i` input 1; `apu_result_i` input 32: response.
- `result_o` output 32: held result.
- `valid_o` output 1: `result_o` valid.
- `ready_o` output 1: 0 while an operation is outstanding.
- `err_o` output 1: sticky protocol/timeout error.

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: `ready_o = ~en_i`. When `en_i & ~flush_i`, latch operator, operands and flags into payload registers, then go to REQ.
- REQ: `apu_req_o=1` with a stable payload. If `flush_i`, go to IDLE with no request lost, because the grant was not taken. Otherwise, on `apu_gnt_i` go to WAIT and clear the timeout counter.
- WAIT: on `apu_rvalid_i`, capture `apu_result_i` into the result register and go to DONE. If `flush_i` occurs without rvalid, go to DRAIN. If `flush_i` and rvalid occur together, discard the result and go to IDLE. If the counter reaches `TIMEOUT_CYCLES` (when nonzero), set result to 0, set `err_o`, and go to DONE.
- DONE: `valid_o=1`, `ready_o=1`. On `ex_ready_i` or `flush_i`, go to IDLE.
- DRAIN: `ready_o=1` (EX is flushed). Wait for `apu_rvalid_i`, discard it, then go to IDLE. The timeout also applies here and sets `err_o`. `en_i` in DRAIN is ignored and stays pending, because `ready_o` of the new instruction is computed in IDLE only after drain.
- `apu_rvalid_i` outside WAIT/DRAIN is ignored and sets `err_o`.
- `apu_gnt_i` outside REQ is ignored.
- Timeout counter: `$clog2(TIMEOUT_CYCLES+1)` bits, saturating, active only in WAIT/DRAIN.
- `err_o` clears only on reset.

## Timing
- Reset values: state IDLE; `apu_req_o=0`; `valid_o=0`; `err_o=0`; `result_o=0`; payload registers 0. `ready_o=1` when `en_i=0`.
- Minimum latency: `en_i` at cycle 0; REQ with gnt at cycle 1; rvalid at cycle 2; `valid_o` at cycle 3. `ready_o` is low on cycles 0–2.
- A grant in the request cycle is allowed. Rvalid is never earlier than the cycle after the grant.
- `apu_req_o` stays high until granted. The payload does not change while `apu_req_o` is high.
- `result_o` holds through DONE stalls of any length.
- Reset mid-operation returns to IDLE asynchronously. A later rvalid then sets `err_o`, which is accepted behaviour.

## Structure
- Shared package `riscv_defines`: `ALU_OP_WIDTH`, VEC_MODE constants, the `alu_offload_state_e` enum, and a new `APU_FLAGS_WIDTH=2`.
- One sub-module, `riscv_alu_offload_timer`: the saturating timeout counter with clear/enable/expired. It is tied off when `TIMEOUT_CYCLES=0`.
- FSM, payload registers and result register live in the top module.

## Test plan
- ALU_MIN, a=32'hFFFF_FFFE, b=5, gnt same cycle, rvalid next with 32'hFFFF_FFFE → `valid_o` at cycle 3, `result_o`=32'hFFFF_FFFE, `ready_o` low for 3 cycles, `err_o`=0.
- Grant withheld 4 cycles while operands on inputs change → `apu_req_o` high 4+ cycles, `apu_operand_*_o` equal the cycle-0 values.
- Flush in REQ before grant → IDLE next cycle, `apu_req_o` drops, no `valid_o`. Flush in WAIT, rvalid 2 cycles later → DRAIN, result discarded, `valid_o` never set.
- `TIMEOUT_CYCLES`=8, no rvalid → DONE after 8 WAIT cycles, `result_o`=0, `err_o`=1 sticky until `rst_n` pulse.
- DONE with `ex_ready_i` low for 5 cycles → `result_o`/`valid_o` stable. `ex_ready_i` high → IDLE, with back-to-back `en_i` accepted the same cycle after.
- Spurious `apu_rvalid_i` in IDLE → `err_o`=1, state unchanged. `rst_n` asserted in WAIT → all outputs at reset values immediately.
